// File: rtl/decode_ctrl_pkg.sv
// Shared types and constants for the decode-stage sequencing controller.
package decode_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    REDIRECT    = 2'd1,
    DRAIN       = 2'd2,
    SERIAL_WAIT = 2'd3
  } dec_ctrl_state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h00000013;
  localparam int          DEC_ADDR_W = 32;

endpackage

// File: rtl/decode_ctrl_if.sv
// Fetch-to-decode handshake channel: fetch is the master, decode_ctrl the slave.
interface decode_ctrl_if
  import decode_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEC_ADDR_W
) ();
  logic                  fetch_valid;
  logic [31:0]           fetch_instr;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  fetch_guess;
  logic [ADDR_WIDTH-1:0] fetch_pred;
  logic                  fetch_ready;

  modport master (
    output fetch_valid, fetch_instr, fetch_pc, fetch_guess, fetch_pred,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid, fetch_instr, fetch_pc, fetch_guess, fetch_pred,
    output fetch_ready
  );
endinterface

// File: rtl/decode_ctrl_slot.sv
// Single-entry instruction slot feeding the decoder: load has priority over clear,
// otherwise contents hold. Clearing drops only the valid bit.
module decode_ctrl_slot
  import decode_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEC_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic [31:0]           i_instr,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_guess,
  input  logic [ADDR_WIDTH-1:0] i_pred,
  output logic                  o_valid,
  output logic [31:0]           o_instr,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_guess,
  output logic [ADDR_WIDTH-1:0] o_pred
);
  logic                  r_vld_p0;
  logic [31:0]           r_instr_p0;
  logic [ADDR_WIDTH-1:0] r_pc_p0;
  logic                  r_guess_p0;
  logic [ADDR_WIDTH-1:0] r_pred_p0;

  // Slot register boundary (stage p0)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p0   <= 1'b0;
      r_instr_p0 <= NOP_INSTR;
      r_pc_p0    <= '0;
      r_guess_p0 <= 1'b0;
      r_pred_p0  <= '0;
    end else if (i_load) begin
      r_vld_p0   <= 1'b1;
      r_instr_p0 <= i_instr;
      r_pc_p0    <= i_pc;
      r_guess_p0 <= i_guess;
      r_pred_p0  <= i_pred;
    end else if (i_clear) begin
      r_vld_p0   <= 1'b0;
    end
  end

  assign o_valid = r_vld_p0;
  assign o_instr = r_instr_p0;
  assign o_pc    = r_pc_p0;
  assign o_guess = r_guess_p0;
  assign o_pred  = r_pred_p0;
endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage sequencing controller: slot, issue handshake and registered redirect.
// Define DECODE_SERIALIZE_EN to serialize CSR/ECALL/EBREAK/AMO against the backend.
module decode_ctrl
  import decode_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEC_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  decode_ctrl_if.slave          io_fetch,
  output logic                  o_dec_valid,
  output logic [31:0]           o_dec_instr,
  output logic [ADDR_WIDTH-1:0] o_dec_pc,
  output logic                  o_dec_guess,
  output logic [ADDR_WIDTH-1:0] o_dec_pred,
  input  logic                  i_dec_inconsistency,
  input  logic [ADDR_WIDTH-1:0] i_dec_new_pc,
  input  logic                  i_dec_serialize,
  output logic                  o_issue_valid,
  input  logic                  i_issue_ready,
  input  logic                  i_backend_empty,
  input  logic                  i_flush,
  input  logic [ADDR_WIDTH-1:0] i_flush_pc,
  output logic                  o_redirect_valid,
  output logic [ADDR_WIDTH-1:0] o_redirect_pc
);
  dec_ctrl_state_t       r_state;
  logic                  r_redirect_valid;
  logic [ADDR_WIDTH-1:0] r_redirect_pc;

  logic w_ser, w_empty, w_active, w_blocked, w_issue, w_ready, w_load, w_clear;

`ifdef DECODE_SERIALIZE_EN
  assign w_ser   = i_dec_serialize;
  assign w_empty = i_backend_empty;
`else
  // Constants collapse the serialization terms; the FSM then stays in RUN/REDIRECT.
  logic w_unused_ser;
  assign w_unused_ser = i_dec_serialize ^ i_backend_empty;
  assign w_ser        = 1'b0;
  assign w_empty      = 1'b1;
`endif

  // DRAIN only marks a slot blocked on the backend; it behaves exactly like RUN.
  assign w_active      = (r_state == RUN) || (r_state == DRAIN);
  assign w_blocked     = o_dec_valid & w_ser & ~w_empty;
  assign o_issue_valid = o_dec_valid & w_active & ~i_flush & (~w_ser | w_empty);
  assign w_issue       = o_issue_valid & i_issue_ready;
  assign w_ready       = w_active & ~i_flush &
                         (~o_dec_valid | (w_issue & ~i_dec_inconsistency & ~w_ser));
  assign w_load        = io_fetch.fetch_valid & w_ready;
  assign w_clear       = i_flush | (w_issue & ~w_load);

  assign io_fetch.fetch_ready = w_ready;

  decode_ctrl_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_instr (io_fetch.fetch_instr),
    .i_pc    (io_fetch.fetch_pc),
    .i_guess (io_fetch.fetch_guess),
    .i_pred  (io_fetch.fetch_pred),
    .o_valid (o_dec_valid),
    .o_instr (o_dec_instr),
    .o_pc    (o_dec_pc),
    .o_guess (o_dec_guess),
    .o_pred  (o_dec_pred)
  );

  // Control FSM boundary: flush outranks everything, including an inconsistency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= RUN;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= 1'b0;
      if (i_flush) begin
        r_state          <= REDIRECT;
        r_redirect_valid <= 1'b1;
        r_redirect_pc    <= i_flush_pc;
      end else begin
        case (r_state)
          RUN, DRAIN: begin
            if (w_issue && i_dec_inconsistency) begin
              r_state          <= REDIRECT;
              r_redirect_valid <= 1'b1;
              r_redirect_pc    <= i_dec_new_pc;
            end else if (w_issue && w_ser) begin
              r_state <= SERIAL_WAIT;
            end else if (w_blocked) begin
              r_state <= DRAIN;
            end else begin
              r_state <= RUN;
            end
          end
          REDIRECT:    r_state <= RUN;
          SERIAL_WAIT: if (w_empty) r_state <= RUN;
          default:     r_state <= RUN;
        endcase
      end
    end
  end

  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;
endmodule

// File: tb/tb_decode_ctrl.sv
// Scoreboard bench for decode_ctrl with a small JAL/SYSTEM decoder stub.
module tb_decode_ctrl;
  import decode_ctrl_pkg::*;

  localparam logic [31:0] ADDI1 = 32'h00100093;
  localparam logic [31:0] ADDI2 = 32'h00200113;
  localparam logic [31:0] JAL40 = 32'h0400006F;   // jal x0, +0x40
  localparam logic [31:0] CSRRW = 32'h30011073;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] o_dec_instr, o_dec_pc, o_dec_pred, o_redirect_pc, i_dec_new_pc, i_flush_pc;
  logic        o_dec_valid, o_dec_guess, o_issue_valid, o_redirect_valid;
  logic        i_dec_inconsistency, i_dec_serialize;
  logic        i_issue_ready = 1'b1, i_backend_empty = 1'b1, i_flush = 1'b0;
  logic [31:0] w_jimm;

  int   n_chk = 0, n_pass = 0;
  exp_t exp_issue[$];
  logic [31:0] exp_redir[$];

  decode_ctrl_if #(.ADDR_WIDTH(32)) fif ();

  decode_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .io_fetch(fif),
    .o_dec_valid(o_dec_valid), .o_dec_instr(o_dec_instr), .o_dec_pc(o_dec_pc),
    .o_dec_guess(o_dec_guess), .o_dec_pred(o_dec_pred),
    .i_dec_inconsistency(i_dec_inconsistency), .i_dec_new_pc(i_dec_new_pc),
    .i_dec_serialize(i_dec_serialize), .o_issue_valid(o_issue_valid),
    .i_issue_ready(i_issue_ready), .i_backend_empty(i_backend_empty),
    .i_flush(i_flush), .i_flush_pc(i_flush_pc),
    .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc)
  );

  // Decoder stub: unpredicted JAL is inconsistent; SYSTEM opcode serializes
  assign w_jimm = {{11{o_dec_instr[31]}}, o_dec_instr[31], o_dec_instr[19:12],
                   o_dec_instr[20], o_dec_instr[30:21], 1'b0};
  assign i_dec_inconsistency = o_dec_valid & (o_dec_instr[6:0] == 7'h6F) & ~o_dec_guess;
  assign i_dec_new_pc        = o_dec_pc + w_jimm;
  assign i_dec_serialize     = o_dec_valid & (o_dec_instr[6:0] == 7'h73);

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    fif.fetch_valid = v;
    fif.fetch_pc    = pc;
    fif.fetch_instr = instr;
    fif.fetch_guess = 1'b0;
    fif.fetch_pred  = pc + 32'd4;
  endtask

  task automatic push_issue(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    exp_issue.push_back(e);
  endtask

  // Monitor: every handshake and every redirect pulse must match the next expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (o_issue_valid && i_issue_ready) begin
        if (exp_issue.size() == 0) chk("issue_unexpected_pc", o_dec_pc, 32'hFFFFFFFF);
        else begin
          exp_t e;
          e = exp_issue.pop_front();
          chk("issue_pc", o_dec_pc, e.pc);
          chk("issue_instr", o_dec_instr, e.instr);
        end
      end
      if (o_redirect_valid) begin
        if (exp_redir.size() == 0) chk("redirect_unexpected_pc", o_redirect_pc, 32'hFFFFFFFF);
        else chk("redirect_pc", o_redirect_pc, exp_redir.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    offer(1'b0, 32'h0, NOP_INSTR);
    i_flush_pc = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dec_instr", o_dec_instr, NOP_INSTR);
    chk("rst_dec_pc", o_dec_pc, 32'h0);
    chk("rst_dec_pred", o_dec_pred, 32'h0);
    chk("rst_dec_guess", {31'd0, o_dec_guess}, 32'd0);
    chk("rst_dec_valid", {31'd0, o_dec_valid}, 32'd0);
    chk("rst_issue_valid", {31'd0, o_issue_valid}, 32'd0);
    chk("rst_redir_valid", {31'd0, o_redirect_valid}, 32'd0);
    chk("rst_redir_pc", o_redirect_pc, 32'h0);
    cyc();
    reset = 1'b0;

    // Back-to-back ADDI
    offer(1'b1, 32'h100, ADDI1); push_issue(32'h100, ADDI1);
    @(negedge clk); chk("rst_fetch_ready", {31'd0, fif.fetch_ready}, 32'd1);
    cyc();
    offer(1'b1, 32'h104, ADDI2); push_issue(32'h104, ADDI2);
    @(negedge clk);
    chk("b2b_issue_valid", {31'd0, o_issue_valid}, 32'd1);
    chk("b2b_fetch_ready", {31'd0, fif.fetch_ready}, 32'd1);
    cyc();
    offer(1'b0, 32'h0, NOP_INSTR);
    @(negedge clk); chk("b2b_second_pc", o_dec_pc, 32'h104);
    cyc();

    // JAL inconsistency redirect; wrong-path 0x204 must never issue
    offer(1'b1, 32'h200, JAL40); push_issue(32'h200, JAL40); exp_redir.push_back(32'h240);
    cyc();
    offer(1'b1, 32'h204, ADDI1);
    @(negedge clk); chk("jal_fetch_ready", {31'd0, fif.fetch_ready}, 32'd0);
    cyc();
    offer(1'b1, 32'h240, ADDI2); push_issue(32'h240, ADDI2);
    @(negedge clk);
    chk("jal_redir_valid", {31'd0, o_redirect_valid}, 32'd1);
    chk("jal_redir_ready", {31'd0, fif.fetch_ready}, 32'd0);
    chk("jal_slot_empty", {31'd0, o_dec_valid}, 32'd0);
    cyc();
    @(negedge clk);
    chk("jal_after_ready", {31'd0, fif.fetch_ready}, 32'd1);
    chk("jal_pulse_len", {31'd0, o_redirect_valid}, 32'd0);
    cyc();
    offer(1'b0, 32'h0, NOP_INSTR);
    cyc();

    // Downstream stall for 3 cycles
    offer(1'b1, 32'h400, ADDI1); push_issue(32'h400, ADDI1);
    i_issue_ready = 1'b0;
    cyc();
    offer(1'b1, 32'h404, ADDI2); push_issue(32'h404, ADDI2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_fetch_ready", {31'd0, fif.fetch_ready}, 32'd0);
      chk("stall_dec_pc", o_dec_pc, 32'h400);
      chk("stall_dec_instr", o_dec_instr, ADDI1);
      chk("stall_dec_pred", o_dec_pred, 32'h404);
      cyc();
    end
    i_issue_ready = 1'b1;
    @(negedge clk); chk("stall_release_ready", {31'd0, fif.fetch_ready}, 32'd1);
    cyc();
    offer(1'b0, 32'h0, NOP_INSTR);
    cyc();

    // Flush wins over a simultaneous inconsistency
    offer(1'b1, 32'h2C0, JAL40); exp_redir.push_back(32'h800);
    cyc();
    offer(1'b0, 32'h0, NOP_INSTR);
    i_flush = 1'b1; i_flush_pc = 32'h800;
    @(negedge clk);
    chk("flush_issue_valid", {31'd0, o_issue_valid}, 32'd0);
    chk("flush_fetch_ready", {31'd0, fif.fetch_ready}, 32'd0);
    cyc();
    i_flush = 1'b0;
    @(negedge clk);
    chk("flush_redir_pc", o_redirect_pc, 32'h800);
    chk("flush_slot_clear", {31'd0, o_dec_valid}, 32'd0);
    cyc();
    cyc();

    // Serializing instruction against a busy backend
    offer(1'b1, 32'h500, CSRRW); push_issue(32'h500, CSRRW);
    i_backend_empty = 1'b0;
    cyc();
    offer(1'b0, 32'h0, NOP_INSTR);
`ifdef DECODE_SERIALIZE_EN
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("ser_wait_issue", {31'd0, o_issue_valid}, 32'd0);
      chk("ser_wait_ready", {31'd0, fif.fetch_ready}, 32'd0);
      cyc();
    end
    i_backend_empty = 1'b1;
    @(negedge clk); chk("ser_issue_valid", {31'd0, o_issue_valid}, 32'd1);
    cyc();
    i_backend_empty = 1'b0;
    @(negedge clk); chk("ser_sw_ready0", {31'd0, fif.fetch_ready}, 32'd0);
    cyc();
    i_backend_empty = 1'b1;
    @(negedge clk); chk("ser_sw_ready1", {31'd0, fif.fetch_ready}, 32'd0);
    cyc();
    @(negedge clk); chk("ser_run_ready", {31'd0, fif.fetch_ready}, 32'd1);
`else
    @(negedge clk);
    chk("ser_off_issue", {31'd0, o_issue_valid}, 32'd1);
    chk("ser_off_ready", {31'd0, fif.fetch_ready}, 32'd1);
    cyc();
    i_backend_empty = 1'b1;
    @(negedge clk); chk("ser_off_ready_after", {31'd0, fif.fetch_ready}, 32'd1);
`endif
    cyc();

    // Reset while a redirect is pending: no pulse, reset values return
    offer(1'b1, 32'h200, JAL40); push_issue(32'h200, JAL40);
    cyc();
    offer(1'b0, 32'h0, NOP_INSTR);
    cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_redir_valid", {31'd0, o_redirect_valid}, 32'd0);
    chk("mrst_redir_pc", o_redirect_pc, 32'h0);
    chk("mrst_dec_instr", o_dec_instr, NOP_INSTR);
    chk("mrst_dec_pc", o_dec_pc, 32'h0);
    chk("mrst_dec_valid", {31'd0, o_dec_valid}, 32'd0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_fetch_ready", {31'd0, fif.fetch_ready}, 32'd1);
    chk("mrst_no_pulse", {31'd0, o_redirect_valid}, 32'd0);
    cyc();
    cyc();

    chk("issue_queue_drained", exp_issue.size(), 32'd0);
    chk("redirect_queue_drained", exp_redir.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
